// File: rtl/config_pkg.sv
// Shared configuration for the systolic accumulator datapath.
// Column count and per-column result width.
package config_pkg;
    localparam int sys_cols   = 4;
    localparam int P_BITWIDTH = 32;
endpackage

// File: rtl/accum_drain.sv
// Accumulator drain: per-column FIFOs re-align skewed column results into
// whole rows, with a pass-level controller that signals when a pass is drained.
module accum_drain
    import config_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [sys_cols-1:0]                 read_out,
    input  logic [sys_cols-1:0][P_BITWIDTH-1:0] o_data,
    input  logic                                acc_done,
    output logic                                row_valid,
    input  logic                                row_ready,
    output logic [sys_cols-1:0][P_BITWIDTH-1:0] row_data,
    output logic [15:0]                         row_idx,
    output logic                                busy,
    output logic                                drain_done,
    output logic                                overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(sys_cols + 1);

    typedef logic [AW:0] ptr_t;
    typedef enum logic [1:0] {IDLE, SKEW, FLUSH, DONE} state_t;

    logic [P_BITWIDTH-1:0] mem [sys_cols][FIFO_DEPTH];
    ptr_t                  wr_ptr [sys_cols];
    ptr_t                  rd_ptr [sys_cols];

    logic [sys_cols-1:0] empty;
    logic [sys_cols-1:0] full;
    logic [sys_cols-1:0] push;
    logic [sys_cols-1:0] drop;
    logic                pop;
    logic                flush;
    logic                all_empty;
    logic                any_empty;

    state_t              state;
    logic [CW-1:0]       skew_cnt;

    // Pointers carry one wrap bit so full and empty differ only in the MSB.
    always_comb begin
        for (int c = 0; c < sys_cols; c++) begin
            empty[c]    = wr_ptr[c] == rd_ptr[c];
            full[c]     = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                          (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
            row_data[c] = mem[c][rd_ptr[c][AW-1:0]];
        end
    end

    assign all_empty = &empty;
    assign any_empty = |empty;
    assign row_valid = ~any_empty;
    assign pop       = row_valid & row_ready;
    assign push      = read_out & (~full | {sys_cols{pop}});
    assign drop      = read_out & full & ~{sys_cols{pop}};

    // Columns out of step with nothing left to arrive: discard the remains.
    assign flush = (state == FLUSH) && any_empty && !all_empty &&
                   (read_out == '0);

    always_ff @(posedge clk) begin
        for (int c = 0; c < sys_cols; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c][AW-1:0]] <= o_data[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < sys_cols; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < sys_cols; c++) begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + ptr_t'(1);
                end
                if (flush) begin
                    rd_ptr[c] <= wr_ptr[c];
                end else if (pop) begin
                    rd_ptr[c] <= rd_ptr[c] + ptr_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            skew_cnt   <= '0;
            busy       <= 1'b0;
            drain_done <= 1'b0;
            row_idx    <= '0;
            overflow   <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            if (|drop || flush) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                row_idx <= row_idx + 16'd1;
            end
            unique case (state)
                IDLE: begin
                    if (acc_done || |read_out) begin
                        busy <= 1'b1;
                    end
                    if (acc_done) begin
                        state    <= SKEW;
                        skew_cnt <= CW'(sys_cols);
                    end
                end
                SKEW: begin
                    if (skew_cnt == '0) begin
                        state <= FLUSH;
                    end else begin
                        skew_cnt <= skew_cnt - CW'(1);
                    end
                end
                FLUSH: begin
                    if (all_empty || flush) begin
                        state      <= DONE;
                        drain_done <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    row_idx <= '0;
                    busy    <= |read_out;
                end
            endcase
        end
    end

endmodule

// File: doc/accum_drain.md
ACCUM_DRAIN -- requirements
Module: accum_drain

Interface
REQ-001 The block SHALL take parameters sys_cols and P_BITWIDTH from the Config package, and local parameter FIFO_DEPTH, default 4, meaning entries per column FIFO (power of two, >= 2).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; 0 forces reset state immediately.
REQ-004 read_out  input  sys_cols  per-column valid strobe from accumulator, column c delayed c cycles from column 0.
REQ-005 o_data  input  sys_cols x P_BITWIDTH  per-column accumulated result, qualified by read_out[c].
REQ-006 acc_done  input  1  single-cycle pulse marking end of an accumulator pass.
REQ-007 row_valid  output  1  an aligned result row is available.
REQ-008 row_ready  input  1  downstream accepts the row when row_valid=1.
REQ-009 row_data  output  sys_cols x P_BITWIDTH  aligned row; element c is from column c.
REQ-010 row_idx  output  16  index of the row currently on row_data, starting at 0 per pass.
REQ-011 busy  output  1  high from acc_done or the first read_out bit until drain_done.
REQ-012 drain_done  output  1  single-cycle pulse when a pass is fully drained.
REQ-013 overflow  output  1  sticky error flag.

Function
REQ-014 Each column c SHALL own a FIFO_DEPTH-entry FIFO; read_out[c]=1 pushes o_data[c] into FIFO c in that cycle.
REQ-015 The k-th push into column c SHALL belong to row k, so de-skew is by per-column arrival order, not by arrival cycle.
REQ-016 row_valid SHALL equal 1 exactly when every column FIFO is non-empty; row_data SHALL be the head of each FIFO.
REQ-017 Latency: a push completing a row at edge N SHALL raise row_valid after edge N; row_valid SHALL not depend combinationally on read_out.
REQ-018 A row SHALL pop from all FIFOs simultaneously on an edge where row_valid=1 and row_ready=1; row_idx SHALL then increment by 1 and wrap modulo 2^16.
REQ-019 While row_valid=1 and row_ready=0, row_data and row_idx SHALL be held stable.
REQ-020 Simultaneous push and pop on the same column SHALL both take effect, including when that FIFO is full.
REQ-021 A push to a full FIFO without a same-cycle pop SHALL be dropped and SHALL set overflow; overflow SHALL clear only by reset.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra bit so that full and empty are distinguishable.
REQ-023 The control FSM SHALL have states IDLE, SKEW, FLUSH, DONE.
REQ-024 IDLE -> SKEW on acc_done=1; SKEW loads a counter with sys_cols and decrements it each cycle, covering the column skew of the final strobes.
REQ-025 SKEW -> FLUSH when the counter reaches 0; pushes during SKEW SHALL be accepted normally.
REQ-026 FLUSH -> DONE when all FIFOs are empty; DONE SHALL assert drain_done for one cycle, clear row_idx to 0, and return to IDLE.
REQ-027 In FLUSH, if some but not all FIFOs are empty with no pushes possible, the block SHALL set overflow, flush all FIFOs, and go to DONE.
REQ-028 acc_done while not in IDLE SHALL be ignored.
REQ-029 Pushes and pops SHALL continue in every state.

Reset
REQ-030 With rst=0: FIFOs empty, FSM=IDLE, row_valid=0, row_idx=0, busy=0, drain_done=0, overflow=0; row_data is don't-care.
REQ-031 Assertion of rst mid-pass SHALL discard all buffered data without emitting drain_done.
REQ-032 The first edge after rst deasserts SHALL be able to accept a push.

Verification
REQ-033 sys_cols=4, P_BITWIDTH=32, row_ready=1; skewed strobes deliver rows {1,2,3,4},{5,6,7,8} -> row_valid once per row, row_idx 0 then 1, row_data exact.
REQ-034 Same stimulus with row_ready=0 for 3 cycles -> row_data {1,2,3,4} held stable, then rows in order, no overflow.
REQ-035 Column 0 receives 5 pushes with row_ready=0 and FIFO_DEPTH=4 -> overflow=1, fifth value lost, first four rows intact.
REQ-036 acc_done pulse after last column-0 strobe -> drain_done exactly once after column 3's last row is popped, then busy=0 and row_idx=0.
REQ-037 Column 0 full, row_ready=1, push and pop in same cycle -> no overflow, occupancy unchanged.
REQ-038 rst=0 asserted during FLUSH with 2 rows pending -> all outputs return to reset values asynchronously, and no drain_done is emitted.
